// File: rtl/interp_pkg.sv
// Shared widths, sample/phase counts and sequencer state encoding for the
// four-pilot linear interpolator.
package interp_pkg;

  localparam int IN_WIDTH_DEF  = 17;
  localparam int OUT_WIDTH_DEF = 19;
  localparam int NUM_SAMPLES   = 13;
  localparam int NUM_PHASES    = 4;
  localparam int NUM_PAIRS     = 3;

  localparam logic [3:0] LAST_IDX   = 4'(NUM_SAMPLES - 1);
  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [1:0] LAST_PAIR  = 2'(NUM_PAIRS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/interp_wsum.sv
// Combinational weighted sum (4-q)*A + q*B, built from shifts and adds only.
// q = 4 yields 4*B, which is how the closing sample 4*e4 is produced.
module interp_wsum
  import interp_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic signed [IN_WIDTH-1:0]  a,
  input  logic signed [IN_WIDTH-1:0]  b,
  input  logic        [2:0]           q,
  output logic signed [OUT_WIDTH-1:0] y
);

  logic signed [OUT_WIDTH-1:0] ax_s;
  logic signed [OUT_WIDTH-1:0] bx_s;

  assign ax_s = {{(OUT_WIDTH - IN_WIDTH){a[IN_WIDTH-1]}}, a};
  assign bx_s = {{(OUT_WIDTH - IN_WIDTH){b[IN_WIDTH-1]}}, b};

  // Select the shift-add form for the requested phase
  always_comb begin
    y = '0;
    case (q)
      3'd0:    y = ax_s <<< 2'd2;
      3'd1:    y = (ax_s <<< 1'd1) + ax_s + bx_s;
      3'd2:    y = (ax_s + bx_s) <<< 1'd1;
      3'd3:    y = ax_s + (bx_s <<< 1'd1) + bx_s;
      3'd4:    y = bx_s <<< 2'd2;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/interp_seq.sv
// Pilot interpolation sequencer: captures e1..e4, then streams 13 samples
// (x4 scaled) under valid/ready flow control with fully registered outputs.
module interp_seq
  import interp_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  e1,
  input  logic signed [IN_WIDTH-1:0]  e2,
  input  logic signed [IN_WIDTH-1:0]  e3,
  input  logic signed [IN_WIDTH-1:0]  e4,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic        [3:0]           out_idx,
  output logic                        out_last
);

  state_t                      state_r;
  state_t                      state_next_s;
  logic signed [IN_WIDTH-1:0]  e_r [4];
  logic [1:0]                  pair_r;
  logic [2:0]                  phase_r;
  logic [1:0]                  pair_next_s;
  logic [2:0]                  phase_next_s;
  logic signed [OUT_WIDTH-1:0] out_data_r;
  logic [3:0]                  out_idx_r;
  logic                        out_valid_r;
  logic                        out_last_r;
  logic                        capture_s;
  logic                        accept_s;
  logic signed [IN_WIDTH-1:0]  a_s;
  logic signed [IN_WIDTH-1:0]  b_s;
  logic [2:0]                  q_s;
  logic signed [OUT_WIDTH-1:0] wsum_s;

  assign in_ready  = (state_r == IDLE);
  assign capture_s = in_valid & in_ready;
  assign accept_s  = out_valid_r & out_ready;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (capture_s) state_next_s = RUN; else state_next_s = IDLE;
      RUN:     if (accept_s && out_last_r) state_next_s = IDLE; else state_next_s = RUN;
      default: state_next_s = IDLE;
    endcase
  end

  // Advance (pair, phase); after the last phase of the last pair, phase 4 selects 4*e4
  always_comb begin
    pair_next_s  = pair_r;
    phase_next_s = phase_r;
    if (phase_r == LAST_PHASE) begin
      if (pair_r == LAST_PAIR) begin
        phase_next_s = 3'd4;
      end else begin
        pair_next_s  = pair_r + 2'd1;
        phase_next_s = 3'd0;
      end
    end else begin
      phase_next_s = phase_r + 3'd1;
    end
  end

  // Operand select: live inputs for sample 0 at capture, captured pilots afterwards
  always_comb begin
    a_s = '0;
    b_s = '0;
    q_s = 3'd0;
    if (state_r == IDLE) begin
      a_s = e1;
      b_s = e2;
      q_s = 3'd0;
    end else begin
      a_s = e_r[pair_next_s];
      b_s = e_r[pair_next_s + 2'd1];
      q_s = phase_next_s;
    end
  end

  interp_wsum #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_wsum (
    .a (a_s),
    .b (b_s),
    .q (q_s),
    .y (wsum_s)
  );

  // Pilot capture, sample counters and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) e_r[i] <= '0;
      pair_r      <= 2'd0;
      phase_r     <= 3'd0;
      out_data_r  <= '0;
      out_idx_r   <= 4'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            e_r[0]      <= e1;
            e_r[1]      <= e2;
            e_r[2]      <= e3;
            e_r[3]      <= e4;
            pair_r      <= 2'd0;
            phase_r     <= 3'd0;
            out_data_r  <= wsum_s;
            out_idx_r   <= 4'd0;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
          end
        end
        RUN: begin
          if (accept_s) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else begin
              pair_r     <= pair_next_s;
              phase_r    <= phase_next_s;
              out_data_r <= wsum_s;
              out_idx_r  <= out_idx_r + 4'd1;
              out_last_r <= (out_idx_r == (LAST_IDX - 4'd1));
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interp_seq.sv
// Scoreboard bench for interp_seq: captured pilot sets are expanded into 13
// expected samples by arithmetic, and a monitor compares each presented sample.
module tb_interp_seq;

  localparam int IW = 17;
  localparam int OW = 19;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] e1, e2, e3, e4;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [3:0]           out_idx;
  logic                 out_last;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   ready_mode = 0;
  bit   garbage = 1'b0;
  bit   cap_prev = 1'b0;
  bit   last_prev = 1'b0;

  interp_seq #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e1        (e1),
    .e2        (e2),
    .e3        (e3),
    .e4        (e4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: linear interpolation between adjacent pilots, scaled by 4
  task automatic push_set(input int a, input int b, input int c, input int d);
    int   ev[4];
    exp_t x;
    ev = '{a, b, c, d};
    for (int k = 0; k < 13; k++) begin
      if (k == 12) x.data = 4 * ev[3];
      else x.data = (4 - k % 4) * ev[k / 4] + (k % 4) * ev[k / 4 + 1];
      x.idx  = k;
      x.last = (k == 12);
      sb.push_back(x);
    end
  endtask

  function automatic logic signed [IW-1:0] rnd();
    logic [31:0] r;
    r = $urandom;
    return r[IW-1:0];
  endfunction

  // Stimulus side: a handshake seen before the edge becomes a scoreboard entry
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) push_set(int'(e1), int'(e2), int'(e3), int'(e4));
  end

  // Monitor: compare whatever the DUT presents against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      cap_prev  <= 1'b0;
      last_prev <= 1'b0;
    end else begin
      if (cap_prev) chk("latency1_valid", int'(out_valid), 1);
      if (last_prev) begin
        chk("ready_after_last", int'(in_ready), 1);
        chk("valid_after_last", int'(out_valid), 0);
      end
      if (out_valid) begin
        chk("ready_low_in_run", int'(in_ready), 0);
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          chk("out_data", int'(out_data), sb[0].data);
          chk("out_idx", int'(out_idx), sb[0].idx);
          chk("out_last", int'(out_last), int'(sb[0].last));
          if (out_ready) void'(sb.pop_front());
        end
      end
      cap_prev  <= in_valid && in_ready;
      last_prev <= out_valid && out_ready && out_last;
    end
  end

  // Downstream ready policy: 0 always ready, 1 random, 2 driven by the main sequence
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Pilot inputs keep changing while garbage mode is on
  always @(posedge clk) begin
    #1;
    if (garbage) begin
      e1 = rnd();
      e2 = rnd();
      e3 = rnd();
      e4 = rnd();
    end
  end

  task automatic send_set(input int a, input int b, input int c, input int d);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    e1 = IW'(a);
    e2 = IW'(b);
    e3 = IW'(c);
    e4 = IW'(d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("timeout_in_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e1 = rnd();
    e2 = rnd();
    e3 = rnd();
    e4 = rnd();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) return;
    end
    fail_now("timeout_drain");
  endtask

  task automatic wait_idx(input int k);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid && int'(out_idx) == k) return;
    end
    fail_now("timeout_wait_idx");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    e1 = '0;
    e2 = '0;
    e3 = '0;
    e4 = '0;
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_idx", int'(out_idx), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Ramp example at full rate
    send_set(4, 8, 0, -4);
    wait_done();

    // Extremes: no overflow at either end
    send_set(-65536, -65536, -65536, -65536);
    wait_done();
    send_set(65535, 65535, 65535, 65535);
    wait_done();
    send_set(65535, -65536, 65535, -65536);
    wait_done();

    // Backpressure for 3 cycles on idx 5
    ready_mode = 2;
    out_ready = 1'b1;
    send_set(4, 8, 0, -4);
    wait_idx(4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_idx", int'(out_idx), 5);
      chk("hold_data", int'(out_data), 24);
      chk("hold_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();
    ready_mode = 0;

    // Reset in the middle of a set
    send_set(4, 8, 0, -4);
    wait_idx(7);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_idx", int'(out_idx), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_out_last", int'(out_last), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", int'(in_ready), 1);
    send_set(-3, 100, -7, 12);
    wait_done();

    // Random sets with random backpressure
    ready_mode = 1;
    repeat (8) begin
      send_set(int'(rnd()), int'(rnd()), int'(rnd()), int'(rnd()));
      wait_done();
    end

    // in_valid held high with changing pilots: captures only when idle
    @(posedge clk);
    #1;
    garbage = 1'b1;
    in_valid = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    in_valid = 1'b0;
    garbage = 1'b0;
    ready_mode = 0;
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/interp_seq.md
INTERP_SEQ -- requirements
Module: interp_seq

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 17, the signed width of each pilot channel estimate.
REQ-002 SHALL have parameter OUT_WIDTH, default 19, the signed width of each 4x-scaled interpolated output; OUT_WIDTH = IN_WIDTH+2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: pilot set e1..e4 valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a pilot set.
REQ-007 SHALL have ports e1, e2, e3, e4, input, IN_WIDTH signed each: pilot estimates in frequency order.
REQ-008 SHALL have port out_valid, output, 1: out_data valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-010 SHALL have port out_data, output, OUT_WIDTH signed: interpolated estimate times 4.
REQ-011 SHALL have port out_idx, output, 4: sample index 0..12 of out_data.
REQ-012 SHALL have port out_last, output, 1: high with out_valid when out_idx = 12.

Function
REQ-013 SHALL implement two states: IDLE (in_ready=1, out_valid=0) and RUN (in_ready=0).
REQ-014 SHALL capture e1..e4 into internal registers on the edge where in_valid & in_ready, and SHALL move IDLE->RUN on that edge.
REQ-015 SHALL present sample 0 with out_valid=1 in the cycle after capture (latency 1).
REQ-016 SHALL produce 13 samples per set. Pair p = 0..2 uses (A,B) = (e[p+1], e[p+2]); phase q = 0..3 gives index 4p+q with out_data = (4-q)*A + q*B. Index 12 = 4*e4.
REQ-017 SHALL form all products by shift-add only: 4A = A<<2, 3A = (A<<1)+A, 2A+2B = (A+B)<<1. No multipliers.
REQ-018 SHALL sign-extend all operands to OUT_WIDTH before adding. Results SHALL never saturate or wrap: the full range fits in OUT_WIDTH.
REQ-019 SHALL advance to the next sample only on the edge where out_valid & out_ready. While out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-020 SHALL return RUN->IDLE on the edge where out_last is accepted; in_ready SHALL be 1 in the following cycle (one idle cycle between sets).
REQ-021 SHALL ignore in_valid and e1..e4 while in RUN. Captured pilots SHALL be unaffected by input changes during RUN.
REQ-022 SHALL keep out_idx at 12 for the final sample until acceptance; there is no wrap-around to 0 without a new capture.

Reset
REQ-023 SHALL, on rst=1, immediately force state=IDLE, out_valid=0, out_last=0, out_idx=0, out_data=0, and pilot registers=0, regardless of clock.
REQ-024 SHALL, on reset during RUN, discard the remaining samples of the set; in_ready=1 from the first clock after rst deasserts.

Structure
REQ-025 SHALL place IN_WIDTH/OUT_WIDTH defaults, sample count 13, phase count 4, and state encodings (IDLE=0, RUN=1) in shared package interp_pkg.
REQ-026 SHALL isolate the combinational weighted sum (A, B, q -> out value) in sub-module interp_wsum. The sequencer, counters (pair 0..2, phase 0..3) and output register SHALL remain in interp_seq.
REQ-027 SHALL register out_data, out_idx, out_valid and out_last directly; no combinational path from in_* to out_*.

Verification
REQ-028 SHALL check: e1=4, e2=8, e3=0, e4=-4, out_ready=1 -> out_data 16,20,24,28,32,24,16,8,0,-4,-8,-12,-16, idx 0..12, out_last only on -16.
REQ-029 SHALL check: all pilots = -65536 -> all 13 outputs = -262144; all pilots = 65535 -> all = 262140 (no overflow).
REQ-030 SHALL check: set of REQ-028, out_ready=0 for 3 cycles when idx=5 -> out_data held at 24, idx 5, then continues with 16 at idx 6.
REQ-031 SHALL check: rst pulsed while idx=7 -> out_valid=0 at once; in_ready=1 after release; a new set restarts at idx 0.
REQ-032 SHALL check: in_valid held high with changing e1..e4 during RUN -> outputs match the captured set; the next capture occurs only in the cycle after out_last is accepted.
